// File: rtl/wavelet_row_scheduler_pkg.sv
// ============================================================================
//  Package     : wavelet_pkg
//  Description : Shared types and default sizes for the row wavelet datapath.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package wavelet_pkg;

    localparam int DEFAULT_LENGTH = 256;
    localparam int DEFAULT_ROWS   = 256;

    typedef logic [7:0] pixel_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_FIRE  = 3'd3,
        S_RUN   = 3'd4,
        S_HOLD  = 3'd5,
        S_DONE  = 3'd6
    } sched_state_t;

    // A single-row frame still needs a one-bit row index.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wavelet_row_scheduler_if.sv
// ============================================================================
//  Interface   : wavelet_row_scheduler_if
//  Description : Image-buffer, engine and sink signals of the row scheduler.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface wavelet_row_scheduler_if #(
    parameter int LENGTH = wavelet_pkg::DEFAULT_LENGTH,
    parameter int ROWS   = wavelet_pkg::DEFAULT_ROWS
);
    localparam int ROW_W = wavelet_pkg::clog2_min1(ROWS);

    logic                  rd_en;
    logic [ROW_W-1:0]      rd_addr;
    logic [LENGTH*8-1:0]   rd_data;
    logic                  cdf_en;
    logic [LENGTH*8-1:0]   cdf_in;
    logic                  cdf_result;
    logic                  out_valid;
    logic [ROW_W-1:0]      out_row;
    logic                  sink_ready;

    modport master (
        output rd_en, rd_addr, cdf_en, cdf_in, out_valid, out_row,
        input  rd_data, cdf_result, sink_ready
    );

    modport slave (
        input  rd_en, rd_addr, cdf_en, cdf_in, out_valid, out_row,
        output rd_data, cdf_result, sink_ready
    );

endinterface

`default_nettype wire

// File: rtl/wavelet_row_scheduler_row_latch.sv
// ============================================================================
//  Module      : row_latch
//  Description : Row-wide pixel register with load enable and synchronous clear.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module row_latch
    import wavelet_pkg::*;
#(
    parameter int LENGTH = DEFAULT_LENGTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [LENGTH*8-1:0] d,
    output logic [LENGTH*8-1:0] q
);

    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        pixel_t r_pix;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_pix <= '0;
            end else if (load) begin
                r_pix <= d[i*8 +: 8];
            end
        end

        assign q[i*8 +: 8] = r_pix;
    end

endmodule

`default_nettype wire

// File: rtl/wavelet_row_scheduler.sv
// ============================================================================
//  Module      : wavelet_row_scheduler
//  Description : Frame controller feeding image rows to the row_to_cdf engine.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module wavelet_row_scheduler
    import wavelet_pkg::*;
#(
    parameter int LENGTH        = DEFAULT_LENGTH,
    parameter int ROWS          = DEFAULT_ROWS,
    parameter int ENGINE_CYCLES = LENGTH + 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    wavelet_row_scheduler_if.master   bus
);

    localparam int ROW_W = clog2_min1(ROWS);
    localparam int CYC_W = $clog2(ENGINE_CYCLES + 1);

    localparam logic [CYC_W-1:0] c_cyc_last = CYC_W'(ENGINE_CYCLES - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(ROWS - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_next;
    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] w_cyc_next;
    logic             w_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_cyc   <= w_cyc_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_row_next    = r_row;
        w_cyc_next    = r_cyc;
        w_load        = 1'b0;
        busy          = (r_state != S_IDLE);
        done          = 1'b0;
        bus.rd_en     = 1'b0;
        bus.cdf_en    = 1'b0;
        bus.out_valid = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                    w_row_next   = '0;
                end
            end
            S_FETCH: begin
                bus.rd_en    = 1'b1;
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_load       = 1'b1;
                w_state_next = S_FIRE;
            end
            S_FIRE: begin
                bus.cdf_en   = 1'b1;
                w_cyc_next   = '0;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                bus.out_valid = bus.cdf_result;
                w_cyc_next    = r_cyc + 1'b1;
                // The sink is consulted only once the engine has drained the row.
                if (r_cyc == c_cyc_last) begin
                    if (r_row == c_row_last) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_row_next   = r_row + 1'b1;
                        w_state_next = bus.sink_ready ? S_FETCH : S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.sink_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.rd_addr = r_row;
    assign bus.out_row = r_row;

    row_latch #(
        .LENGTH (LENGTH)
    ) u_row_latch (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .d     (bus.rd_data),
        .q     (bus.cdf_in)
    );

endmodule

`default_nettype wire
